count8_cmd_seq: RTL

//   Command sequencer directly upstream of the 8-bit loadable counter.

---
 rtl/count8_cmd_seq.sv | 124 ++++++++++++
 1 files changed

// File: rtl/count8_cmd_seq.sv
// Command sequencer for an 8-bit loadable counter: turns LOAD/RUN/HOLD/NOP commands
// into cycle-accurate EN/load/CNT_In drive, with busy and a done pulse per command.
module count8_cmd_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  input  logic             abort,
  output logic             EN,
  output logic             load,
  output logic [WIDTH-1:0] CNT_In,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HOLD = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_LOAD = 2'b01,
    OP_RUN  = 2'b10,
    OP_HOLD = 2'b11
  } op_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_cnt_in;
  logic             r_en;
  logic             r_load;
  logic             r_done;
  logic             w_accept;

  // NOTE: ready also drops combinationally on abort and reset so that neither can
  // coincide with an accept at the same edge.
  assign cmd_ready = (r_state == S_IDLE) && !abort && !res;
  assign w_accept  = cmd_valid && cmd_ready;

  assign EN     = r_en;
  assign load   = r_load;
  assign CNT_In = r_cnt_in;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;

  // EN/load are registered alongside the next state, so they always equal the
  // decode of r_state (EN in LOAD/RUN, load in LOAD) without a combinational path.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_cnt_in <= '0;
      r_en     <= 1'b0;
      r_load   <= 1'b0;
      r_done   <= 1'b0;
    end else if (abort) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_en    <= 1'b0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_en   <= 1'b0;
      r_load <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            unique case (op_t'(cmd_op))
              OP_LOAD: begin
                r_state  <= S_LOAD;
                r_cnt_in <= cmd_arg;
                r_en     <= 1'b1;
                r_load   <= 1'b1;
              end
              OP_RUN: begin
                if (cmd_arg != '0) begin
                  r_state <= S_RUN;
                  r_rem   <= cmd_arg;
                  r_en    <= 1'b1;
                end else begin
                  r_done <= 1'b1;
                end
              end
              OP_HOLD: begin
                if (cmd_arg != '0) begin
                  r_state <= S_HOLD;
                  r_rem   <= cmd_arg;
                end else begin
                  r_done <= 1'b1;
                end
              end
              default: r_done <= 1'b1;
            endcase
          end
        end
        S_LOAD: begin
          r_state <= S_IDLE;
          r_done  <= 1'b1;
        end
        S_RUN, S_HOLD: begin
          // rem counts the cycles still to spend here, including this one.
          if (r_rem > WIDTH'(1)) begin
            r_rem <= r_rem - WIDTH'(1);
            r_en  <= (r_state == S_RUN);
          end else begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
